// File: rtl/tick_bcd_stopwatch.sv
// BCD stopwatch counting rising edges of a slow divided square wave, with start/pause/clear and lap freeze.
// tick_clk is sampled as data: a count lands SYNC_STAGES edges after tick_clk is first seen high.
module tick_bcd_stopwatch #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_FPGA,
    input  logic                  reset,
    input  logic                  tick_clk,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   bcd_count,
    output logic [4*DIGITS-1:0]   bcd_display,
    output logic                  running,
    output logic                  lap_active,
    output logic                  overflow
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   edge_q, edge_d;
    logic [4*DIGITS-1:0]    count_q, count_d;
    logic [4*DIGITS-1:0]    lap_q, lap_d;
    logic                   lap_active_q, lap_active_d;
    logic                   overflow_q, overflow_d;

    logic                   sync_out;
    logic                   tick_en;
    logic [4*DIGITS-1:0]    count_inc;
    logic                   carry;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], tick_clk};
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign edge_d   = sync_out;
    assign tick_en  = sync_out & ~edge_q;

    // Ripple BCD increment; a carry out of the top digit means all-9s wrapped to zero.
    always_comb begin
        count_inc = count_q;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        lap_d        = lap_q;
        lap_active_d = lap_active_q;
        overflow_d   = overflow_q;

        if (clear) begin
            state_d      = S_IDLE;
            count_d      = '0;
            lap_d        = '0;
            lap_active_d = 1'b0;
            overflow_d   = 1'b0;
        end else begin
            // The tick is judged against the current state, before any start_stop transition.
            if (state_q == S_RUN && tick_en) begin
                count_d = count_inc;
                if (carry) begin
                    overflow_d = 1'b1;
                end
            end

            if (start_stop) begin
                case (state_q)
                    S_IDLE:  state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = S_IDLE;
                endcase
            end

            // Lap follows the rules of the state being entered; capture is pre-increment.
            if (lap) begin
                if (state_d == S_RUN) begin
                    if (lap_active_q) begin
                        lap_active_d = 1'b0;
                    end else begin
                        lap_d        = count_q;
                        lap_active_d = 1'b1;
                    end
                end else if (state_d == S_PAUSE) begin
                    lap_active_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_FPGA or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            edge_q       <= 1'b0;
            count_q      <= '0;
            lap_q        <= '0;
            lap_active_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            edge_q       <= edge_d;
            count_q      <= count_d;
            lap_q        <= lap_d;
            lap_active_q <= lap_active_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bcd_count   = count_q;
    assign bcd_display = lap_active_q ? lap_q : count_q;
    assign running     = (state_q == S_RUN);
    assign lap_active  = lap_active_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_tick_bcd_stopwatch.sv
// Directed table of pulse/tick steps with expected outputs, plus short hand-written timing sequences.
module tb_tick_bcd_stopwatch;

    logic        clk_FPGA = 1'b0;
    logic        reset;
    logic        tick_clk;
    logic        start_stop;
    logic        clear;
    logic        lap;
    logic [15:0] bcd_count;
    logic [15:0] bcd_display;
    logic        running;
    logic        lap_active;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    tick_bcd_stopwatch #(.DIGITS(4), .SYNC_STAGES(2)) dut (
        .clk_FPGA    (clk_FPGA),
        .reset       (reset),
        .tick_clk    (tick_clk),
        .start_stop  (start_stop),
        .clear       (clear),
        .lap         (lap),
        .bcd_count   (bcd_count),
        .bcd_display (bcd_display),
        .running     (running),
        .lap_active  (lap_active),
        .overflow    (overflow)
    );

    always #5 clk_FPGA = ~clk_FPGA;

    typedef struct {
        bit          ss;
        bit          lp;
        bit          clr;
        int          seq;
        int          ticks;
        logic [15:0] cnt;
        logic [15:0] disp;
        bit          run;
        bit          lapa;
        bit          ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(bit ss, bit lp, bit clr, int seq, int ticks,
                               logic [15:0] cnt, logic [15:0] disp, bit run, bit lapa, bit ovf);
        vec_t r;
        r.ss = ss; r.lp = lp; r.clr = clr; r.seq = seq; r.ticks = ticks;
        r.cnt = cnt; r.disp = disp; r.run = run; r.lapa = lapa; r.ovf = ovf;
        return r;
    endfunction

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_FPGA);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] cnt, input logic [15:0] disp,
                           input bit run, input bit lapa, input bit ovf);
        chk({tag, ".count"},   bcd_count,   cnt);
        chk({tag, ".display"}, bcd_display, disp);
        chk({tag, ".running"}, running,     run);
        chk({tag, ".lap"},     lap_active,  lapa);
        chk({tag, ".ovf"},     overflow,    ovf);
    endtask

    // Slow ticks toggle every 4 cycles; bulk ticks use a 2/2 pattern to keep run time down.
    task automatic ticks(input int n);
        int half;
        half = (n > 50) ? 2 : 4;
        for (int k = 0; k < n; k++) begin
            tick_clk = 1'b1;
            step(half);
            tick_clk = 1'b0;
            step(half);
        end
    endtask

    task automatic run_seq(input int id);
        case (id)
            1: begin // latency: count moves exactly two edges after first high sample
                tick_clk = 1'b1;
                step(); chk("lat.n",   bcd_count, 16'h0012);
                step(); chk("lat.n+1", bcd_count, 16'h0012);
                step(); chk("lat.n+2", bcd_count, 16'h0013);
                step();
                tick_clk = 1'b0;
                step(4);
            end
            2: begin // long high level is a single tick
                tick_clk = 1'b1;
                step(20);
                chk("held.mid", bcd_count, 16'h0014);
                tick_clk = 1'b0;
                step(4);
            end
            3: begin // pause request in the same cycle as tick_en
                tick_clk = 1'b1;
                step(2);
                start_stop = 1'b1;
                step();
                start_stop = 1'b0;
                chk("coinc.count", bcd_count, 16'h0008);
                step(1);
                tick_clk = 1'b0;
                step(4);
            end
            4: begin // asynchronous reset between edges
                #2 reset = 1'b0;
                #1 chk_all("areset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
                #3 reset = 1'b1;
                step();
            end
            default: ;
        endcase
    endtask

    initial begin
        reset = 1'b0; tick_clk = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;

        //              ss lp cl seq ticks  count     display   run lap ovf
        tbl.push_back(v(1, 0, 0, 0,  0,    16'h0000, 16'h0000, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  12,   16'h0012, 16'h0012, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 1,  0,    16'h0013, 16'h0013, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 2,  0,    16'h0014, 16'h0014, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  5,    16'h0005, 16'h0005, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  0,    16'h0005, 16'h0005, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  3,    16'h0005, 16'h0005, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  2,    16'h0007, 16'h0007, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 3,  0,    16'h0008, 16'h0008, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  99,   16'h0099, 16'h0099, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1,    16'h0100, 16'h0100, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  9899, 16'h9999, 16'h9999, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0,  1,    16'h0000, 16'h0000, 1, 0, 1));
        tbl.push_back(v(0, 1, 0, 0,  3,    16'h0003, 16'h0000, 1, 1, 1));
        tbl.push_back(v(1, 0, 1, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  25,   16'h0025, 16'h0025, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0,  0,    16'h0025, 16'h0025, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0,  5,    16'h0030, 16'h0025, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  0,    16'h0030, 16'h0030, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  2,    16'h0002, 16'h0002, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0,  1,    16'h0003, 16'h0002, 1, 1, 0));
        tbl.push_back(v(1, 0, 0, 0,  0,    16'h0003, 16'h0002, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 0,  0,    16'h0003, 16'h0003, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0,  0,    16'h0003, 16'h0003, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0,  0,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  42,   16'h0042, 16'h0042, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 4,  3,    16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0,  1,    16'h0001, 16'h0001, 1, 0, 0));

        step(2);
        chk_all("reset", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].seq != 0) run_seq(tbl[i].seq);
            if (tbl[i].ss || tbl[i].lp || tbl[i].clr) begin
                start_stop = tbl[i].ss;
                lap        = tbl[i].lp;
                clear      = tbl[i].clr;
                step();
                start_stop = 1'b0;
                lap        = 1'b0;
                clear      = 1'b0;
            end
            if (tbl[i].ticks != 0) ticks(tbl[i].ticks);
            chk_all($sformatf("v%0d", i), tbl[i].cnt, tbl[i].disp,
                    tbl[i].run, tbl[i].lapa, tbl[i].ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
